// File: rtl/uart_cmd_if.sv
// uart_cmd_if
// Bundles the byte stream from the UART receiver, the command handshake toward
// the application, the payload read port and the status/error pulses of
// uart_cmd_controller.
//   rx_valid/rx_data                 byte strobe and byte from the receiver
//   cmd_valid/cmd_ack                pending-command handshake
//   cmd_code/cmd_len                 code and payload length of the pending frame
//   rd_addr/rd_data                  combinational payload read port
//   busy                             controller is inside a frame or holding one
//   err_chk/err_len/err_timeout      single-cycle error pulses
//   overrun                          single-cycle byte-dropped pulse
// Modport slave is the controller side; master is the receiver/application side.
`timescale 1ns/1ps
interface uart_cmd_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       cmd_valid;
    logic       cmd_ack;
    logic [7:0] cmd_code;
    logic [3:0] cmd_len;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;
    logic       err_chk;
    logic       err_len;
    logic       err_timeout;
    logic       overrun;

    modport slave (
        input  rx_valid, rx_data, cmd_ack, rd_addr,
        output cmd_valid, cmd_code, cmd_len, rd_data, busy,
               err_chk, err_len, err_timeout, overrun
    );

    modport master (
        output rx_valid, rx_data, cmd_ack, rd_addr,
        input  cmd_valid, cmd_code, cmd_len, rd_data, busy,
               err_chk, err_len, err_timeout, overrun
    );
endinterface

// File: rtl/uart_cmd_controller.sv
// uart_cmd_controller
// Assembles frames of the form SYNC, CMD, LEN, payload[LEN], XOR checksum from
// the receiver's one-cycle byte strobes. A frame whose checksum matches is held
// for the application (cmd_valid until cmd_ack). Bad length, bad checksum,
// inter-byte timeout and bytes arriving while a command is held are reported
// as registered one-cycle pulses.
// Ports:
//   clk_50MHz  system clock
//   reset      asynchronous, active-high; aborts any frame and clears the payload
//   bus        uart_cmd_if.slave (see rtl/uart_cmd_if.sv for the signal list)
`timescale 1ns/1ps
module uart_cmd_controller #(
    parameter int         MAX_LEN        = 8,
    parameter logic [7:0] SYNC_BYTE      = 8'hAA,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic       clk_50MHz,
    input  logic       reset,
    uart_cmd_if.slave  bus
);

    localparam int                 CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]         MAX_LEN_B  = 8'(MAX_LEN);
    localparam logic [3:0]         MAX_LEN_N  = 4'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_HOLD
    } state_t;

    state_t           state, state_next;
    logic [7:0]       code_q;
    logic [3:0]       len_q;
    logic [3:0]       idx_q;
    logic [7:0]       chk_q;
    logic [CNT_W-1:0] cnt_q;
    // Indexed directly by the 4-bit idx/rd_addr; entries at or above MAX_LEN
    // are never written and stay at their reset value.
    logic [7:0]       pay_buf [16];

    logic err_chk_q, err_len_q, err_timeout_q, overrun_q;
    logic err_chk_next, err_len_next, err_timeout_next, overrun_next;
    logic expire;

    // A byte on the expiry cycle takes priority over the timeout.
    assign expire = (cnt_q == CNT_LAST) && !bus.rx_valid;

    always_comb begin
        state_next       = state;
        err_chk_next     = 1'b0;
        err_len_next     = 1'b0;
        err_timeout_next = 1'b0;
        overrun_next     = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.rx_valid && bus.rx_data == SYNC_BYTE)
                    state_next = S_CMD;
            end
            S_CMD: begin
                if (bus.rx_valid) begin
                    state_next = S_LEN;
                end else if (expire) begin
                    state_next       = S_IDLE;
                    err_timeout_next = 1'b1;
                end
            end
            S_LEN: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data > MAX_LEN_B) begin
                        state_next   = S_IDLE;
                        err_len_next = 1'b1;
                    end else if (bus.rx_data == 8'h00) begin
                        state_next = S_CHK;
                    end else begin
                        state_next = S_PAYLOAD;
                    end
                end else if (expire) begin
                    state_next       = S_IDLE;
                    err_timeout_next = 1'b1;
                end
            end
            S_PAYLOAD: begin
                if (bus.rx_valid) begin
                    if (idx_q == len_q - 4'd1)
                        state_next = S_CHK;
                end else if (expire) begin
                    state_next       = S_IDLE;
                    err_timeout_next = 1'b1;
                end
            end
            S_CHK: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == chk_q) begin
                        state_next = S_HOLD;
                    end else begin
                        state_next   = S_IDLE;
                        err_chk_next = 1'b1;
                    end
                end else if (expire) begin
                    state_next       = S_IDLE;
                    err_timeout_next = 1'b1;
                end
            end
            S_HOLD: begin
                // Bytes are dropped here even when cmd_ack releases the hold
                // on the same cycle; they never restart frame detection.
                if (bus.rx_valid)
                    overrun_next = 1'b1;
                if (bus.cmd_ack)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            code_q        <= '0;
            len_q         <= '0;
            idx_q         <= '0;
            chk_q         <= '0;
            cnt_q         <= '0;
            err_chk_q     <= 1'b0;
            err_len_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            overrun_q     <= 1'b0;
            for (int i = 0; i < 16; i++)
                pay_buf[i] <= '0;
        end else begin
            state         <= state_next;
            err_chk_q     <= err_chk_next;
            err_len_q     <= err_len_next;
            err_timeout_q <= err_timeout_next;
            overrun_q     <= overrun_next;

            // Inter-byte counter: idle outside the frame body, restarted by
            // every accepted byte.
            if (bus.rx_valid || state_next == S_IDLE || state_next == S_HOLD)
                cnt_q <= '0;
            else
                cnt_q <= cnt_q + CNT_W'(1);

            if (bus.rx_valid) begin
                case (state)
                    S_CMD: begin
                        code_q <= bus.rx_data;
                        chk_q  <= bus.rx_data;
                    end
                    S_LEN: begin
                        if (bus.rx_data <= MAX_LEN_B) begin
                            len_q <= bus.rx_data[3:0];
                            chk_q <= chk_q ^ bus.rx_data;
                            idx_q <= '0;
                        end
                    end
                    S_PAYLOAD: begin
                        pay_buf[idx_q] <= bus.rx_data;
                        chk_q          <= chk_q ^ bus.rx_data;
                        idx_q          <= idx_q + 4'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.cmd_valid   = (state == S_HOLD);
    assign bus.busy        = (state != S_IDLE);
    assign bus.cmd_code    = code_q;
    assign bus.cmd_len     = len_q;
    assign bus.rd_data     = (bus.rd_addr < MAX_LEN_N) ? pay_buf[bus.rd_addr] : 8'h00;
    assign bus.err_chk     = err_chk_q;
    assign bus.err_len     = err_len_q;
    assign bus.err_timeout = err_timeout_q;
    assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_uart_cmd_controller.sv
`timescale 1ns/1ps
module tb_uart_cmd_controller;

    localparam int MAX_LEN = 8;
    localparam int TO      = 40;

    logic clk_50MHz = 1'b0;
    logic reset     = 1'b0;
    always #10 clk_50MHz = ~clk_50MHz;

    uart_cmd_if bus ();

    uart_cmd_controller #(
        .MAX_LEN        (MAX_LEN),
        .SYNC_BYTE      (8'hAA),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_50MHz (clk_50MHz),
        .reset     (reset),
        .bus       (bus)
    );

    int checks = 0;
    int errors = 0;

    // Pulse monitor: counts each pulse and any pulse lasting more than one cycle.
    int n_chk = 0, n_len = 0, n_to = 0, n_ovr = 0, n_wide = 0;
    int exp_chk = 0, exp_len = 0, exp_to = 0, exp_ovr = 0;
    logic [3:0] prev_p = 4'b0;
    always @(posedge clk_50MHz) begin
        logic [3:0] p;
        p = {bus.err_chk, bus.err_len, bus.err_timeout, bus.overrun};
        if (p[3]) n_chk++;
        if (p[2]) n_len++;
        if (p[1]) n_to++;
        if (p[0]) n_ovr++;
        if ((p & prev_p) != 4'b0) n_wide++;
        prev_p = p;
    end

    logic [7:0] pl[$];   // payload of the frame under test (reference)
    logic [7:0] fr[$];   // bytes to transmit

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the consuming posedge.
    task automatic send(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk_50MHz);
        bus.rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_50MHz);
    endtask

    task automatic send_fr(input int max_gap);
        foreach (fr[i]) begin
            send(fr[i]);
            if (max_gap > 0 && i != fr.size() - 1) idle($urandom_range(0, max_gap));
        end
    endtask

    function automatic logic [7:0] non_sync();
        logic [7:0] b;
        do b = 8'($urandom); while (b == 8'hAA);
        return b;
    endfunction

    // Checksum from frame fields: XOR of code, length and every payload byte.
    function automatic logic [7:0] frame_xor(input logic [7:0] code, input logic [7:0] len);
        logic [7:0] x;
        x = code ^ len;
        foreach (pl[i]) x ^= pl[i];
        return x;
    endfunction

    task automatic build(input logic [7:0] code, input logic [7:0] len, input logic [7:0] chk_flip);
        fr = {8'hAA, code, len};
        foreach (pl[i]) fr.push_back(pl[i]);
        fr.push_back(frame_xor(code, len) ^ chk_flip);
    endtask

    task automatic expect_pending(input string tag, input logic [7:0] code);
        check({tag, " cmd_valid"}, 32'(bus.cmd_valid), 32'd1);
        check({tag, " busy"},      32'(bus.busy),      32'd1);
        check({tag, " cmd_code"},  32'(bus.cmd_code),  32'(code));
        check({tag, " cmd_len"},   32'(bus.cmd_len),   32'(pl.size()));
        foreach (pl[i]) begin
            bus.rd_addr = 4'(i);
            #1 check($sformatf("%s rd_data[%0d]", tag, i), 32'(bus.rd_data), 32'(pl[i]));
            @(negedge clk_50MHz);
        end
        bus.rd_addr = 4'($urandom_range(MAX_LEN, 15));
        #1 check({tag, " rd_data beyond MAX_LEN"}, 32'(bus.rd_data), 32'd0);
        @(negedge clk_50MHz);
    endtask

    task automatic ack(input string tag);
        bus.cmd_ack = 1'b1;
        @(negedge clk_50MHz);
        bus.cmd_ack = 1'b0;
        check({tag, " cmd_valid after ack"}, 32'(bus.cmd_valid), 32'd0);
        check({tag, " busy after ack"},      32'(bus.busy),      32'd0);
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.cmd_ack  = 1'b0;
        bus.rd_addr  = 4'd0;

        // Reset state
        @(negedge clk_50MHz);
        reset = 1'b1;
        idle(2);
        check("reset cmd_valid", 32'(bus.cmd_valid), 32'd0);
        check("reset busy",      32'(bus.busy),      32'd0);
        check("reset cmd_code",  32'(bus.cmd_code),  32'd0);
        check("reset cmd_len",   32'(bus.cmd_len),   32'd0);
        check("reset pulses",    32'({bus.err_chk, bus.err_len, bus.err_timeout, bus.overrun}), 32'd0);
        #1 check("reset rd_data", 32'(bus.rd_data), 32'd0);
        @(negedge clk_50MHz);
        reset = 1'b0;
        idle(1);

        // Basic frame AA 05 03 11 22 33 06
        pl = {8'h11, 8'h22, 8'h33};
        fr = {8'hAA, 8'h05, 8'h03, 8'h11, 8'h22, 8'h33, 8'h06};
        send_fr(0);
        expect_pending("basic", 8'h05);
        ack("basic");

        // Garbage then zero-length frame
        pl = {};
        fr = {8'h00, 8'hFF, 8'hAA, 8'h10, 8'h00, 8'h10};
        send_fr(0);
        check("zero-len no err", 32'({bus.err_chk, bus.err_len, bus.err_timeout}), 32'd0);
        expect_pending("zero-len", 8'h10);
        ack("zero-len");

        // Bad checksum, then a good frame
        fr = {8'hAA, 8'h05, 8'h01, 8'h44, 8'h00};
        send_fr(0);
        exp_chk++;
        check("badchk err_chk",   32'(bus.err_chk),   32'd1);
        check("badchk cmd_valid", 32'(bus.cmd_valid), 32'd0);
        check("badchk busy",      32'(bus.busy),      32'd0);
        idle(1);
        check("badchk pulse width", 32'(bus.err_chk), 32'd0);
        pl = {8'h5A};
        build(8'h07, 8'h01, 8'h00);
        send_fr(0);
        expect_pending("after badchk", 8'h07);
        ack("after badchk");

        // Length too large, trailing bytes ignored
        fr = {8'hAA, 8'h05, 8'h09};
        send_fr(0);
        exp_len++;
        check("badlen err_len", 32'(bus.err_len), 32'd1);
        check("badlen busy",    32'(bus.busy),    32'd0);
        fr = {8'h11, 8'h22, 8'h33};
        send_fr(0);
        check("badlen trailing ignored", 32'(bus.busy), 32'd0);

        // Timeout: fires exactly TO cycles after the last byte
        fr = {8'hAA, 8'h05};
        send_fr(0);
        idle(TO - 1);
        check("timeout not yet", 32'(bus.err_timeout), 32'd0);
        check("timeout still busy", 32'(bus.busy), 32'd1);
        idle(1);
        exp_to++;
        check("timeout pulse", 32'(bus.err_timeout), 32'd1);
        check("timeout idle",  32'(bus.busy),        32'd0);
        idle(1);
        check("timeout pulse width", 32'(bus.err_timeout), 32'd0);

        // Byte on the expiry cycle wins
        fr = {8'hAA, 8'h05};
        send_fr(0);
        idle(TO - 1);
        send(8'h00);
        check("expiry byte no timeout", 32'(bus.err_timeout), 32'd0);
        check("expiry byte busy",       32'(bus.busy),        32'd1);
        send(8'h05);
        pl = {};
        expect_pending("expiry byte", 8'h05);
        ack("expiry byte");

        // Overrun in HOLD with and without coincident ack
        pl = {8'hAB, 8'hCD};
        build(8'h21, 8'h02, 8'h00);
        send_fr(0);
        idle(TO + 5);
        send(8'hAA);
        exp_ovr++;
        check("overrun pulse", 32'(bus.overrun), 32'd1);
        expect_pending("overrun held", 8'h21);
        bus.cmd_ack = 1'b1;
        send(8'hAA);
        bus.cmd_ack = 1'b0;
        exp_ovr++;
        check("overrun+ack pulse",     32'(bus.overrun),   32'd1);
        check("overrun+ack cmd_valid", 32'(bus.cmd_valid), 32'd0);
        check("overrun+ack busy",      32'(bus.busy),      32'd0);
        send(8'h05);
        check("dropped AA no sync", 32'(bus.busy), 32'd0);

        // Randomized frames against the frame-level reference
        for (int n = 0; n < 24; n++) begin
            int kind;
            int len;
            logic [7:0] code;
            kind = $urandom_range(0, 3);
            code = 8'($urandom);
            repeat ($urandom_range(0, 2)) send(non_sync());
            pl = {};
            if (kind == 3) begin
                len = $urandom_range(MAX_LEN + 1, 255);
                fr = {8'hAA, code, 8'(len)};
                send_fr(3);
                exp_len++;
                check($sformatf("rnd%0d err_len", n), 32'(bus.err_len), 32'd1);
                repeat ($urandom_range(0, 3)) send(non_sync());
                check($sformatf("rnd%0d badlen idle", n), 32'(bus.busy), 32'd0);
            end else begin
                len = $urandom_range(0, MAX_LEN);
                repeat (len) pl.push_back(8'($urandom));
                if (kind == 2) begin
                    build(code, 8'(len), 8'($urandom_range(1, 255)));
                    send_fr(3);
                    exp_chk++;
                    check($sformatf("rnd%0d err_chk", n),   32'(bus.err_chk),   32'd1);
                    check($sformatf("rnd%0d no cmd", n),    32'(bus.cmd_valid), 32'd0);
                end else begin
                    build(code, 8'(len), 8'h00);
                    send_fr(3);
                    check($sformatf("rnd%0d no err", n), 32'(bus.err_chk), 32'd0);
                    expect_pending($sformatf("rnd%0d", n), code);
                    ack($sformatf("rnd%0d", n));
                end
            end
            idle($urandom_range(0, 2));
        end

        // Reset mid-payload
        fr = {8'hAA, 8'h33, 8'h04, 8'h01, 8'h02};
        send_fr(0);
        check("midpayload busy", 32'(bus.busy), 32'd1);
        #3 reset = 1'b1;
        #2;
        check("midreset busy",     32'(bus.busy),      32'd0);
        check("midreset cmd_valid",32'(bus.cmd_valid), 32'd0);
        check("midreset cmd_code", 32'(bus.cmd_code),  32'd0);
        check("midreset cmd_len",  32'(bus.cmd_len),   32'd0);
        check("midreset pulses",   32'({bus.err_chk, bus.err_len, bus.err_timeout, bus.overrun}), 32'd0);
        @(negedge clk_50MHz);
        for (int i = 0; i < 16; i++) begin
            bus.rd_addr = 4'(i);
            #1 check($sformatf("midreset buf[%0d]", i), 32'(bus.rd_data), 32'd0);
        end
        @(negedge clk_50MHz);
        reset = 1'b0;
        idle(1);
        pl = {8'h9C, 8'h3E};
        build(8'h44, 8'h02, 8'h00);
        send_fr(0);
        expect_pending("after reset", 8'h44);
        ack("after reset");
        idle(3);

        // Pulse totals from the monitor against the reference tallies
        check("total err_chk",     32'(n_chk),  32'(exp_chk));
        check("total err_len",     32'(n_len),  32'(exp_len));
        check("total err_timeout", 32'(n_to),   32'(exp_to));
        check("total overrun",     32'(n_ovr),  32'(exp_ovr));
        check("pulse width",       32'(n_wide), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
